rv_fifo_bridge: RTL and testbench
=================================

# rv_fifo_bridge

Parametrised ready/valid transfer buffer: the multi-entry successor to the single-beat handshake register. It accepts words from an upstream producer over a valid/ready port and queues up to DEPTH of them in order. It presents them downstream over a second valid/ready port, gated by a transmit enable. It reports each completed downstream transfer with a one-cycle done pulse and exposes occupancy. It sits between the operand/result streams and the systolic MAC array, where producer and consumer stall independently.

## Interface
- DATA_W, 64, word width in bits.
- DEPTH, 4, number of storage entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH+1), derived width of count; not overridden.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk, 0 = reset.
- in_valid  in  1  upstream word present on in_data.
- in_ready  out  1  buffer can accept a word this cycle.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  head word offered downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head word.
- en_data_Tx  in  1  downstream transmit enable; 0 holds all queued words.
- flush  in  1  synchronous discard of all queued words.
- tx_done  out  1  registered one-cycle pulse per completed downstream transfer.
- count  out  CNT_W  number of words held, 0..DEPTH.

## Operation
- Storage: DEPTH × DATA_W register array, write pointer and read pointer of $clog2(DEPTH) bits, plus a count register.
- Pointers wrap from DEPTH-1 to 0; full/empty are decided by count, not by pointer compare.
- push = in_valid & in_ready. On push: mem[wr_ptr] ← in_data, wr_ptr+1.
- pop = out_valid & out_ready. On pop: rd_ptr+1.
- count: +1 on push only; -1 on pop only; unchanged on both or neither.
- in_ready = (count < DEPTH) & ~flush, combinational. It is 0 when full, even if a pop occurs the same cycle; there is no full-bypass.
- out_valid = (count ≠ 0) & en_data_Tx & ~flush, combinational.
- out_data = mem[rd_ptr] when count ≠ 0, else all zeros. It is independent of en_data_Tx, so the head is visible while stalled.
- There is no empty pass-through: a word pushed into an empty buffer is not offered in the same cycle.
- Order is strictly FIFO; no word is dropped or duplicated except by flush or reset.
- Occupancy states, derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- State transitions: EMPTY→PARTIAL on push; PARTIAL→FULL on push without pop at count = DEPTH-1; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop without push at count = 1; any state→EMPTY on flush or reset.
- Once out_valid is high, it deasserts only by pop, by en_data_Tx falling, or by flush. out_data for the head does not change while out_valid is high and out_ready is low.
- tx_done ← pop, registered; flush or reset force it to 0.
- Flush: pointers and count go to 0 at the next edge. Pushes and pops that cycle are suppressed because in_ready and out_valid are forced low. Storage contents are not cleared.
- Reset dominates flush.

## Timing
- Reset values (cycle after reset sampled 0): in_ready 1, out_valid 0, out_data 0, tx_done 0, count 0, pointers 0.
- Latency: a word pushed at edge N is offered (out_valid = 1, given en_data_Tx) in the cycle after edge N.
- tx_done is high for the one cycle following the pop edge. Back-to-back pops give tx_done high on consecutive cycles.
- count reflects push/pop at the edge and updates in the same cycle tx_done rises.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset asserted mid-transfer: the handshake in the reset cycle does not take effect; all state returns to reset values at that edge.
- en_data_Tx low: pushes continue until FULL; count and pointers hold once full.

## Test plan
- Reset, then DEPTH=4: push 0xDEADBEEFCAFEBABE with out_ready=0, en_data_Tx=1 -> count=1, out_valid=1 next cycle, out_data=0xDEADBEEFCAFEBABE; raise out_ready -> one tx_done pulse, count=0, out_data=0.
- Push 5 words 0x1..0x5 with en_data_Tx=0 -> in_ready=0 after 4th, count=4, 5th held; set en_data_Tx=1, out_ready=1 -> out order 0x1,0x2,0x3,0x4,0x5, 5 consecutive tx_done pulses.
- Streaming at count=2 with in_valid=1, out_ready=1 for 8 cycles -> count stays 2, pointers wrap twice, output sequence equals input sequence, tx_done high each cycle.
- Full with out_ready=1 and in_valid=1 same cycle -> pop only, count 4→3, no push, in_ready=1 next cycle.
- Flush asserted with count=3 and out_ready=1 -> no tx_done, count=0, out_valid=0 next cycle; a following push of 0xA5 is read out as 0xA5.
- reset driven 0 for one cycle at count=2 mid-handshake -> all outputs at reset values next cycle, no tx_done.

Source files
------------

// File: rtl/rv_fifo_bridge.sv
// Ready/valid FIFO buffer between producer and consumer streams with independent stalls.
// Downstream offer is gated by en_data_Tx; each completed downstream transfer pulses tx_done.
module rv_fifo_bridge #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              en_data_Tx,
  input  logic              flush,
  output logic              tx_done,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;

  // Occupancy decides full/empty; pointer equality is ambiguous.
  always_comb begin
    empty     = (count == CNT_W'(0));
    full      = (count == CNT_W'(DEPTH));
    in_ready  = ~full & ~flush;
    out_valid = ~empty & en_data_Tx & ~flush;
    out_data  = empty ? DATA_W'(0) : mem[rd_ptr];
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Storage array: written on push only, never cleared.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and completion pulse; reset dominates flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_done <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fifo_bridge.sv
// Directed, table-driven bench for rv_fifo_bridge (DEPTH=4, DATA_W=64).
// Each row drives inputs at the falling edge and checks outputs before the next rising edge.
module tb_rv_fifo_bridge;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              en_data_Tx;
  logic              flush;
  logic              tx_done;
  logic [CNT_W-1:0]  count;

  int checks;
  int failures;

  rv_fifo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .en_data_Tx(en_data_Tx), .flush(flush), .tx_done(tx_done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst_n;
    logic              iv;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              en;
    logic              fl;
    logic              e_ir;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic              e_done;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst_n, logic iv, logic [DATA_W-1:0] id, logic ordy,
                              logic en, logic fl, logic e_ir, logic e_ov,
                              logic [DATA_W-1:0] e_od, logic e_done, logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.id = id; v.ordy = ordy; v.en = en; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic iv, input logic [DATA_W-1:0] id,
                       input logic ordy, input logic en, input logic fl);
    reset = rst_n; in_valid = iv; in_data = id; out_ready = ordy; en_data_Tx = en; flush = fl;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    //        rst iv  data                     ordy en  fl | ir ov  out_data                 done cnt
    // single word through, out_ready low first
    vq.push_back(mk(1, 1, 64'hDEADBEEFCAFEBABE, 0, 1, 0,   1, 0, 64'h0,                  0, 0));
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 1, 64'hDEADBEEFCAFEBABE,   0, 1));
    vq.push_back(mk(1, 0, 64'h0,                1, 1, 0,   1, 1, 64'hDEADBEEFCAFEBABE,   0, 1));
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 0, 64'h0,                  1, 0));
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 0, 64'h0,                  0, 0));
    // fill with transmit disabled; fifth word held off
    vq.push_back(mk(1, 1, 64'h1,                0, 0, 0,   1, 0, 64'h0,                  0, 0));
    vq.push_back(mk(1, 1, 64'h2,                0, 0, 0,   1, 0, 64'h1,                  0, 1));
    vq.push_back(mk(1, 1, 64'h3,                0, 0, 0,   1, 0, 64'h1,                  0, 2));
    vq.push_back(mk(1, 1, 64'h4,                0, 0, 0,   1, 0, 64'h1,                  0, 3));
    vq.push_back(mk(1, 1, 64'h5,                0, 0, 0,   0, 0, 64'h1,                  0, 4));
    // full with push and pop requested: pop only
    vq.push_back(mk(1, 1, 64'h5,                1, 1, 0,   0, 1, 64'h1,                  0, 4));
    vq.push_back(mk(1, 1, 64'h5,                1, 1, 0,   1, 1, 64'h2,                  1, 3));
    vq.push_back(mk(1, 0, 64'h0,                1, 1, 0,   1, 1, 64'h3,                  1, 3));
    vq.push_back(mk(1, 0, 64'h0,                1, 1, 0,   1, 1, 64'h4,                  1, 2));
    vq.push_back(mk(1, 0, 64'h0,                1, 1, 0,   1, 1, 64'h5,                  1, 1));
    vq.push_back(mk(1, 0, 64'h0,                1, 1, 0,   1, 0, 64'h0,                  1, 0));
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 0, 64'h0,                  0, 0));
    // stream at count=2 for 8 cycles
    vq.push_back(mk(1, 1, 64'h10,               0, 1, 0,   1, 0, 64'h0,                  0, 0));
    vq.push_back(mk(1, 1, 64'h11,               0, 1, 0,   1, 1, 64'h10,                 0, 1));
    for (int k = 0; k < 8; k++) begin
      vq.push_back(mk(1, 1, 64'(32'h12 + k), 1, 1, 0, 1, 1, 64'(32'h10 + k),
                      (k == 0) ? 1'b0 : 1'b1, 2));
    end
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 1, 64'h18,                 1, 2));
    // flush at count=3, then a fresh word
    vq.push_back(mk(1, 1, 64'h1A,               0, 1, 0,   1, 1, 64'h18,                 0, 2));
    vq.push_back(mk(1, 1, 64'hFF,               1, 1, 1,   0, 0, 64'h18,                 0, 3));
    vq.push_back(mk(1, 1, 64'hA5,               0, 1, 0,   1, 0, 64'h0,                  0, 0));
    vq.push_back(mk(1, 0, 64'h0,                1, 1, 0,   1, 1, 64'hA5,                 0, 1));
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 0, 64'h0,                  1, 0));
    // reset mid-handshake at count=2
    vq.push_back(mk(1, 1, 64'h21,               0, 1, 0,   1, 0, 64'h0,                  0, 0));
    vq.push_back(mk(1, 1, 64'h22,               0, 1, 0,   1, 1, 64'h21,                 0, 1));
    vq.push_back(mk(0, 1, 64'h23,               1, 1, 0,   1, 1, 64'h21,                 0, 2));
    vq.push_back(mk(1, 0, 64'h0,                0, 1, 0,   1, 0, 64'h0,                  0, 0));

    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst_n, vq[i].iv, vq[i].id, vq[i].ordy, vq[i].en, vq[i].fl);
      #1;
      chk("in_ready",  i, 64'(in_ready),  64'(vq[i].e_ir));
      chk("out_valid", i, 64'(out_valid), 64'(vq[i].e_ov));
      chk("out_data",  i, out_data,       vq[i].e_od);
      chk("tx_done",   i, 64'(tx_done),   64'(vq[i].e_done));
      chk("count",     i, 64'(count),     64'(vq[i].e_cnt));
    end

    // Stall with out_ready high but transmit disabled: head visible, nothing leaves.
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h77, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("stall_valid", 100 + k, 64'(out_valid), 64'h0);
      chk("stall_data",  100 + k, out_data,       64'h77);
      chk("stall_count", 100 + k, 64'(count),     64'h1);
      chk("stall_done",  100 + k, 64'(tx_done),   64'h0);
    end

    // Re-enable and wait, bounded, for the completion pulse.
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        #1;
        if (tx_done === 1'b1) seen = 1'b1;
      end
      chk("release_done", 200, 64'(seen), 64'h1);
      chk("release_count", 200, 64'(count), 64'h0);
      chk("release_valid", 200, 64'(out_valid), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
